mem_interface: RTL and testbench

MEM_INTERFACE -- requirements
Module: mem_interface

---
 rtl/cpu_pkg.sv | 28 ++
 rtl/mem_interface_rise_detect.sv | 36 +++
 rtl/mem_interface.sv | 227 ++++++++++++++++++++++
 tb/tb_mem_interface.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// ============================================================================
// Module      : cpu_pkg
// Description : Shared types and constants for the CPU memory interface.
//               Provides the memory FSM state enum, the default word and
//               address widths, and the data pattern that is loaded on a
//               read timeout.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_ADDR_W = 9;

    // Loaded into MDR when a read gives up waiting for the RAM
    localparam logic [31:0] MEM_TIMEOUT_PATTERN = 32'hDEADBEEF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RD_REQ = 2'd1,
        WR_REQ = 2'd2,
        DONE   = 2'd3
    } mem_state_t;

endpackage : cpu_pkg

`default_nettype wire

// File: rtl/mem_interface_rise_detect.sv
// ============================================================================
// Module      : rise_detect
// Description : 1-bit rising-edge detector. The previous value of d is held
//               in a register; rise is high while d=1 and the registered
//               copy is still 0, so a level held for many cycles yields one
//               single-cycle pulse.
// Ports       : clk  - clock
//               rst  - asynchronous active-low reset (clears history)
//               d    - level input
//               rise - rising-edge pulse
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);

    logic r_prev;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= d;
        end
    end

    assign rise = d & ~r_prev;

endmodule : rise_detect

`default_nettype wire

// File: rtl/mem_interface.sv
// ============================================================================
// Module      : mem_interface
// Description : MAR/MDR memory interface between a CPU bus and a RAM with a
//               single-cycle completion handshake. Rising edges of the level
//               commands Read and ramWE each start one transaction from IDLE;
//               a simultaneous rise starts the read only. Edges seen while a
//               transaction is in progress are discarded.
// Options     : MEM_TIMEOUT_EN - when defined, a wait counter aborts a
//               transaction after TIMEOUT cycles without mem_ack, sets the
//               sticky err flag and (for reads with MDRin) loads MDR with
//               MEM_TIMEOUT_PATTERN. Undefined: waits forever, err = 0.
// Ports       : clk, rst (async active-low)
//               BusMuxOut, MARin, MDRin, Read, ramWE - CPU side
//               MDR_q                                - MDR to CPU bus
//               mem_addr, mem_wdata, mem_re, mem_we  - RAM request
//               mem_rdata, mem_ack                   - RAM response
//               busy, done, err                      - status
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_interface
    import cpu_pkg::*;
#(
    parameter int DATA_W  = DEFAULT_DATA_W,
    parameter int ADDR_W  = DEFAULT_ADDR_W,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] BusMuxOut,
    input  logic              MARin,
    input  logic              MDRin,
    input  logic              Read,
    input  logic              ramWE,
    output logic [DATA_W-1:0] MDR_q,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_re,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              busy,
    output logic              done,
    output logic              err
);

    mem_state_t        r_state;
    mem_state_t        w_next;
    logic [ADDR_W-1:0] r_mar;
    logic [ADDR_W-1:0] r_req_addr;
    logic [DATA_W-1:0] r_mdr;
    logic [DATA_W-1:0] r_wdata;
    logic              w_read_rise;
    logic              w_we_rise;
    logic              w_timeout;

    // ------------------------------------------------------------------
    // Command edge detection (tracks in every state, so edges that land
    // outside IDLE are consumed and never issue late)
    // ------------------------------------------------------------------
    rise_detect u_read_rise (
        .clk  (clk),
        .rst  (rst),
        .d    (Read),
        .rise (w_read_rise)
    );

    rise_detect u_we_rise (
        .clk  (clk),
        .rst  (rst),
        .d    (ramWE),
        .rise (w_we_rise)
    );

    // ------------------------------------------------------------------
    // Optional wait-state timeout
    // ------------------------------------------------------------------
`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] r_wait;
    logic             r_err;

    // Counter is zero in IDLE/DONE, so it always starts at 0 on entry
    // to a request state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wait <= '0;
        end else if (r_state == RD_REQ || r_state == WR_REQ) begin
            r_wait <= r_wait + 1'b1;
        end else begin
            r_wait <= '0;
        end
    end

    // An ack on the last allowed cycle still completes normally.
    assign w_timeout = (r_state == RD_REQ || r_state == WR_REQ) &&
                       !mem_ack && (r_wait == CNT_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err <= 1'b0;
        end else if (w_timeout) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    assign w_timeout = 1'b0;
    assign err       = 1'b0;

    // TIMEOUT is only meaningful with the timeout option; this empty block
    // references it so both builds share one parameter list.
    if (TIMEOUT < 1) begin : g_timeout_param_unused
    end
`endif

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state. Read has priority over a simultaneous write rise.
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_read_rise) begin
                    w_next = RD_REQ;
                end else if (w_we_rise) begin
                    w_next = WR_REQ;
                end
            end
            RD_REQ, WR_REQ: begin
                if (mem_ack || w_timeout) begin
                    w_next = DONE;
                end
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs, decoded from state so that an asynchronous reset
    // drops the strobes without waiting for a clock edge
    // ------------------------------------------------------------------
    always_comb begin
        mem_re = 1'b0;
        mem_we = 1'b0;
        busy   = 1'b0;
        done   = 1'b0;
        unique case (r_state)
            RD_REQ: begin
                mem_re = 1'b1;
                busy   = 1'b1;
            end
            WR_REQ: begin
                mem_we = 1'b1;
                busy   = 1'b1;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mar      <= '0;
            r_mdr      <= '0;
            r_req_addr <= '0;
            r_wdata    <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (MARin) begin
                        r_mar <= BusMuxOut[ADDR_W-1:0];
                    end
                    // With Read high, MDRin means "capture from memory",
                    // so the bus is not sampled.
                    if (MDRin && !Read) begin
                        r_mdr <= BusMuxOut;
                    end
                    // Address is taken from the MAR value before any load
                    // on this same edge.
                    if (w_read_rise || w_we_rise) begin
                        r_req_addr <= r_mar;
                    end
                    if (w_we_rise && !w_read_rise) begin
                        r_wdata <= r_mdr;
                    end
                end
                RD_REQ: begin
                    if (MDRin) begin
                        if (mem_ack) begin
                            r_mdr <= mem_rdata;
                        end else if (w_timeout) begin
                            r_mdr <= DATA_W'(MEM_TIMEOUT_PATTERN);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign MDR_q     = r_mdr;
    assign mem_addr  = r_req_addr;
    assign mem_wdata = r_wdata;

endmodule : mem_interface

`default_nettype wire

// File: tb/tb_mem_interface.sv
// ============================================================================
// Module      : tb_mem_interface
// Description : Self-checking bench for mem_interface. A RAM responder acks
//               after a programmable number of strobe cycles; a monitor
//               counts strobe cycles and done pulses. Expected values come
//               from a small MAR/MDR model and per-transaction arithmetic.
//               Build with MEM_TIMEOUT_EN to include the timeout scenario.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_interface;

    localparam int DW = 32;
    localparam int AW = 9;
    localparam int TO = 16;

    logic          clk;
    logic          rst_n;
    logic [DW-1:0] bus;
    logic          mar_in;
    logic          mdr_in;
    logic          rd;
    logic          we;
    logic [DW-1:0] mdr_q;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_re;
    logic          mem_we;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;
    logic          busy;
    logic          done;
    logic          err;

    mem_interface #(
        .DATA_W  (DW),
        .ADDR_W  (AW),
        .TIMEOUT (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst_n),
        .BusMuxOut (bus),
        .MARin     (mar_in),
        .MDRin     (mdr_in),
        .Read      (rd),
        .ramWE     (we),
        .MDR_q     (mdr_q),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_re    (mem_re),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- RAM responder ----------------
    int          ack_delay = 0;   // strobe cycles before the ack cycle
    int          wait_cnt  = 0;
    logic        ram_ack   = 1'b0;
    logic        ack_force = 1'b0;
    assign mem_ack = ram_ack | ack_force;

    always @(negedge clk) begin
        if (rst_n && (mem_re || mem_we)) begin
            if (wait_cnt == ack_delay) begin
                ram_ack  = 1'b1;
                wait_cnt = 0;
            end else begin
                ram_ack  = 1'b0;
                wait_cnt = wait_cnt + 1;
            end
        end else begin
            ram_ack  = 1'b0;
            wait_cnt = 0;
        end
    end

    // ---------------- Monitor ----------------
    int            cyc = 0;
    int            re_cycles = 0, we_cycles = 0, done_cnt = 0, done_cyc = 0;
    logic [AW-1:0] re_addr = '0, we_addr = '0;
    logic [DW-1:0] we_data = '0;

    always @(posedge clk) cyc = cyc + 1;

    always @(negedge clk) begin
        if (mem_re) begin
            re_cycles = re_cycles + 1;
            re_addr   = mem_addr;
        end
        if (mem_we) begin
            we_cycles = we_cycles + 1;
            we_addr   = mem_addr;
            we_data   = mem_wdata;
        end
        if (done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
    end

    // ---------------- Checking helpers ----------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next falling edge (monitor has sampled)
    task automatic nstep(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    int b_re, b_we, b_done, t_start;

    task automatic mark();
        b_re    = re_cycles;
        b_we    = we_cycles;
        b_done  = done_cnt;
        t_start = cyc;
    endtask

    task automatic wait_done(input int budget);
        int i = 0;
        while (done_cnt == b_done && i < budget) begin
            nstep(1);
            i++;
        end
    endtask

    // ---------------- Reference model ----------------
    logic [AW-1:0] m_mar = '0;
    logic [DW-1:0] m_mdr = '0;

    task automatic load_mar(input logic [DW-1:0] v);
        bus    = v;
        mar_in = 1'b1;
        nstep(1);
        mar_in = 1'b0;
        m_mar  = v[AW-1:0];
    endtask

    task automatic load_mdr(input logic [DW-1:0] v);
        bus    = v;
        mdr_in = 1'b1;
        nstep(1);
        mdr_in = 1'b0;
        m_mdr  = v;
    endtask

    // One read: strobe lasts delay+1 cycles; the command cycle, strobe
    // cycles and done cycle are consecutive, so done is seen delay+2
    // clock edges after the command is raised.
    task automatic do_read(input logic [DW-1:0] data, input int delay,
                           input bit use_mdr, input int hold);
        mark();
        ack_delay = delay;
        mem_rdata = data;
        rd        = 1'b1;
        mdr_in    = use_mdr;
        wait_done(60);
        nstep(hold);
        rd     = 1'b0;
        mdr_in = 1'b0;
        nstep(2);
        if (use_mdr) m_mdr = data;
        chk("rd_strobe_cycles", re_cycles - b_re, delay + 1);
        chk("rd_addr", re_addr, m_mar);
        chk("rd_no_we", we_cycles - b_we, 0);
        chk("rd_done_pulses", done_cnt - b_done, 1);
        chk("rd_latency", done_cyc - t_start, delay + 2);
        chk("rd_mdr", mdr_q, m_mdr);
        chk("rd_idle_busy", busy, 1'b0);
    endtask

    task automatic do_write(input int delay, input int hold);
        mark();
        ack_delay = delay;
        we        = 1'b1;
        wait_done(60);
        nstep(hold);
        we = 1'b0;
        nstep(2);
        chk("wr_strobe_cycles", we_cycles - b_we, delay + 1);
        chk("wr_addr", we_addr, m_mar);
        chk("wr_data", we_data, m_mdr);
        chk("wr_no_re", re_cycles - b_re, 0);
        chk("wr_done_pulses", done_cnt - b_done, 1);
        chk("wr_latency", done_cyc - t_start, delay + 2);
        chk("wr_mdr_kept", mdr_q, m_mdr);
    endtask

    // ---------------- Watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- Directed + random sequence ----------------
    initial begin
        rst_n     = 1'b0;
        bus       = '0;
        mar_in    = 1'b0;
        mdr_in    = 1'b0;
        rd        = 1'b0;
        we        = 1'b0;
        mem_rdata = '0;
        nstep(2);

        // Reset state
        chk("rst_mdr", mdr_q, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_re", mem_re, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        rst_n = 1'b1;
        nstep(2);

        // Read at 0x042, ack after two wait cycles, MDR captures data
        load_mar(32'h0000_0042);
        do_read(32'h1234_5678, 2, 1'b1, 1);
        chk("s1_addr_042", re_addr, 9'h042);
        chk("s1_mdr", mdr_q, 32'h1234_5678);

        // Write 0xA5A5A5A5 to 0x1FF with a zero-wait RAM
        load_mdr(32'hA5A5_A5A5);
        load_mar(32'h0000_01FF);
        do_write(0, 2);
        chk("s2_wdata", we_data, 32'hA5A5_A5A5);
        chk("s2_addr", we_addr, 9'h1FF);

        // Simultaneous Read and ramWE rise: read only, write dropped
        load_mar($urandom);
        mark();
        ack_delay = 1;
        mem_rdata = $urandom;
        rd = 1'b1;
        we = 1'b1;
        wait_done(60);
        nstep(3);
        rd = 1'b0;
        we = 1'b0;
        nstep(4);
        chk("sim_re_cycles", re_cycles - b_re, 2);
        chk("sim_no_we", we_cycles - b_we, 0);
        chk("sim_done", done_cnt - b_done, 1);
        chk("sim_mdr_kept", mdr_q, m_mdr);

        // Second Read rise while busy is discarded
        load_mar($urandom);
        mark();
        ack_delay = 4;
        mem_rdata = $urandom;
        rd     = 1'b1;
        mdr_in = 1'b1;
        nstep(2);
        rd = 1'b0;
        nstep(1);
        rd = 1'b1;
        wait_done(60);
        nstep(4);
        rd     = 1'b0;
        mdr_in = 1'b0;
        nstep(2);
        m_mdr = mem_rdata;
        chk("busy2_re_cycles", re_cycles - b_re, 5);
        chk("busy2_done", done_cnt - b_done, 1);
        chk("busy2_mdr", mdr_q, m_mdr);

        // Asynchronous reset in the middle of a read
        load_mar($urandom);
        ack_delay = 1000;
        rd     = 1'b1;
        mdr_in = 1'b1;
        nstep(3);
        chk("arst_pre_re", mem_re, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_re", mem_re, 1'b0);
        chk("arst_busy", busy, 1'b0);
        chk("arst_mdr", mdr_q, 0);
        chk("arst_addr", mem_addr, 0);
        rd     = 1'b0;
        mdr_in = 1'b0;
        m_mar  = '0;
        m_mdr  = '0;
        nstep(1);
        rst_n = 1'b1;
        nstep(2);
        mark();
        mem_rdata = 32'hCAFE_F00D;
        ack_force = 1'b1;
        nstep(1);
        ack_force = 1'b0;
        nstep(2);
        chk("stray_ack_mdr", mdr_q, 0);
        chk("stray_ack_done", done_cnt - b_done, 0);
        chk("stray_ack_busy", busy, 1'b0);

        // Randomized transactions
        for (int n = 0; n < 24; n++) begin
            load_mar($urandom);
            if ($urandom_range(0, 1) == 1) begin
                if ($urandom_range(0, 1) == 1) load_mdr($urandom);
                do_read($urandom, int'($urandom_range(0, 3)),
                        1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
            end else begin
                load_mdr($urandom);
                do_write(int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
            end
        end

`ifdef MEM_TIMEOUT_EN
        // Read with no ack: aborts after TO strobe cycles
        load_mar($urandom);
        mark();
        ack_delay = 1000;
        rd     = 1'b1;
        mdr_in = 1'b1;
        wait_done(60);
        nstep(1);
        rd     = 1'b0;
        mdr_in = 1'b0;
        nstep(2);
        chk("to_re_cycles", re_cycles - b_re, TO);
        chk("to_done", done_cnt - b_done, 1);
        chk("to_err", err, 1'b1);
        chk("to_mdr", mdr_q, 32'hDEADBEEF);
`else
        chk("err_tied_low", err, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_mem_interface

`default_nettype wire
